sram_axi_bridge: RTL and testbench

//  Responder for the sram-like data interface driven by the L1 caches: accepts one
//  req/wr/size/addr/wdata transaction, performs it as a single-beat AXI4 master

---
 rtl/sram_axi_bridge.sv | 190 +++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// ============================================================================
// Module   : sram_axi_bridge
// Purpose  : sram-like slave port to single-beat AXI4 master, one outstanding.
//            Optional macro SRAM_BRIDGE_WR_FAST_OK_EN: early write data_ok.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_axi_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    wr,
    input  logic [1:0]              size,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [3:0]              arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arsize,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata_axi,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata_axi,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AWW  = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
    logic                    fast_ok_q, fast_ok_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
            fast_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
            fast_ok_q <= fast_ok_d;
`endif
        end
    end

    // Transfer attributes come only from the latched request, so they stay
    // stable while any VALID is waiting for its READY.
    always_comb begin
        arid      = AXI_ID;
        awid      = AXI_ID;
        araddr    = addr_q;
        awaddr    = addr_q;
        arsize    = (size_q == 2'b11) ? 3'b010 : {1'b0, size_q};
        awsize    = arsize;
        wdata_axi = wdata_q;
        wlast     = 1'b1;
        rdata     = rdata_q;
        case (size_q)
            2'b00:   wstrb = 4'b0001 << addr_q[1:0];
            2'b01:   wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
        fast_ok_d = 1'b0;
`endif
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst so the combinational accept is quiet during reset.
                addr_ok = req & rst;
                if (req) begin
                    wr_d      = wr;
                    size_d    = size;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata_axi;
                    state_d = S_DONE;
                end
            end
            S_AWW: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awready) aw_done_d = 1'b1;
                if (wready)  w_done_d  = 1'b1;
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = S_B;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
                    fast_ok_d = 1'b1;
`endif
                end
            end
            S_B: begin
                bready = 1'b1;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
                data_ok = fast_ok_q;
                if (bvalid) state_d = S_IDLE;
`else
                if (bvalid) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                data_ok = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
// ============================================================================
// Module   : tb_sram_axi_bridge
// Purpose  : Randomized and directed bench for sram_axi_bridge against a
//            transaction-level model of the handshake rules.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        addr_ok, data_ok;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, wdata_axi;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata_axi = '0;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
        .awready(awready), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;
    req_t rq[$];

    int p_ar = 100, p_r = 100, p_aw = 100, p_w = 100, p_b = 100;
    logic        fix_rd = 1'b0;
    logic [31:0] fix_val = '0;

    // Model of the bridge as seen at transaction level.
    logic        m_busy = 0, m_wr = 0, m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0, m_dk = 0;
    logic [1:0]  m_size = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic        acc_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_size(input logic [1:0] s);
        return (s == 2'd3) ? 3'd2 : {1'b0, s};
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [31:0] a);
        int lane = int'(a % 4);
        if (s == 2'd0) return 4'(1 << lane);
        if (s == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    always @(negedge clk) begin : cmp
        logic e_aok, e_dok, e_arv, e_rr, e_awv, e_wv, e_br;
        if (!rst) begin
            chk("rst addr_ok", {31'd0, addr_ok}, 0);
            chk("rst data_ok", {31'd0, data_ok}, 0);
            chk("rst valids", {28'd0, arvalid, awvalid, wvalid, 1'b0}, 0);
            chk("rst readies", {30'd0, rready, bready}, 0);
            chk("rst rdata", rdata, 0);
            m_busy = 0; m_rdata = 0; acc_seen = 0;
            m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; m_dk = 0;
        end else begin
            e_aok = !m_busy && req;
            e_arv = m_busy && !m_wr && !m_ar;
            e_rr  = m_busy && !m_wr && m_ar && !m_r;
            e_awv = m_busy && m_wr && !m_aw;
            e_wv  = m_busy && m_wr && !m_w;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
            e_br  = m_busy && m_wr && m_aw && m_w;
            e_dok = m_busy && ((!m_wr && m_r) || (m_wr && m_aw && m_w && !m_dk));
`else
            e_br  = m_busy && m_wr && m_aw && m_w && !m_b;
            e_dok = m_busy && ((!m_wr && m_r) || (m_wr && m_b));
`endif
            chk("addr_ok", {31'd0, addr_ok}, {31'd0, e_aok});
            chk("data_ok", {31'd0, data_ok}, {31'd0, e_dok});
            chk("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
            chk("rready",  {31'd0, rready},  {31'd0, e_rr});
            chk("awvalid", {31'd0, awvalid}, {31'd0, e_awv});
            chk("wvalid",  {31'd0, wvalid},  {31'd0, e_wv});
            chk("bready",  {31'd0, bready},  {31'd0, e_br});
            chk("rdata",   rdata, m_rdata);
            if (e_arv) begin
                chk("araddr", araddr, m_addr);
                chk("arsize", {29'd0, arsize}, {29'd0, exp_size(m_size)});
                chk("arid", {28'd0, arid}, 32'd1);
            end
            if (e_awv) begin
                chk("awaddr", awaddr, m_addr);
                chk("awsize", {29'd0, awsize}, {29'd0, exp_size(m_size)});
                chk("awid", {28'd0, awid}, 32'd1);
            end
            if (e_wv) begin
                chk("wdata_axi", wdata_axi, m_wdata);
                chk("wstrb", {28'd0, wstrb}, {28'd0, exp_strb(m_size, m_addr)});
                chk("wlast", {31'd0, wlast}, 32'd1);
            end
            if (e_arv && arready) m_ar = 1;
            if (e_rr && rvalid) begin m_r = 1; m_rdata = rdata_axi; end
            if (e_awv && awready) m_aw = 1;
            if (e_wv && wready) m_w = 1;
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
            if (e_dok) m_dk = 1;
            if (e_dok && !m_wr) m_busy = 0;
            if (e_br && bvalid) m_busy = 0;
`else
            if (e_br && bvalid) m_b = 1;
            if (e_dok) m_busy = 0;
`endif
            acc_seen = e_aok;
            if (e_aok) begin
                m_busy = 1; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
                m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; m_dk = 0;
            end
        end
    end

    always @(posedge clk) begin : drv
        req_t r;
        #2;
        if (!rst) begin
            req = 0;
        end else begin
            if (req && acc_seen) req = 0;
            if (!req && rq.size() > 0) begin
                r = rq.pop_front();
                req = 1; wr = r.w; size = r.s; addr = r.a; wdata = r.d;
            end
        end
        arready   = (int'($urandom_range(99)) < p_ar);
        awready   = (int'($urandom_range(99)) < p_aw);
        wready    = (int'($urandom_range(99)) < p_w);
        rvalid    = m_busy && !m_wr && m_ar && !m_r && (int'($urandom_range(99)) < p_r);
        bvalid    = m_busy && m_wr && m_aw && m_w && !m_b && (int'($urandom_range(99)) < p_b);
        rdata_axi = fix_rd ? fix_val : $urandom;
    end

    task automatic push(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.w = w; r.s = s; r.a = a; r.d = d;
        rq.push_back(r);
    endtask

    task automatic cyc_at();
        @(posedge clk);
        #7;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_busy || req || rq.size() > 0) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 3000) begin
            total++; bad++;
            $display("FAIL idle timeout: bridge still busy after %0d cycles", k);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic all_ready();
        p_ar = 100; p_r = 100; p_aw = 100; p_w = 100; p_b = 100;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1;
        wait_idle();

        // Read word, ready-high slave.
        all_ready(); fix_rd = 1; fix_val = 32'hDEAD_BEEF;
        push(0, 2'd2, 32'h1000_0004, 0);
        cyc_at(); chk("t1 addr_ok@0", {31'd0, addr_ok}, 1);
        cyc_at(); chk("t1 arvalid@1", {31'd0, arvalid}, 1);
        chk("t1 araddr", araddr, 32'h1000_0004);
        chk("t1 arsize", {29'd0, arsize}, 2);
        cyc_at(); chk("t1 rready@2", {31'd0, rready}, 1);
        cyc_at(); chk("t1 data_ok@3", {31'd0, data_ok}, 1);
        chk("t1 rdata", rdata, 32'hDEAD_BEEF);
        fix_rd = 0;
        wait_idle();

        // Byte and half writes.
        push(1, 2'd0, 32'h2000_0003, 32'hAB00_0000);
        cyc_at(); chk("t2 addr_ok@0", {31'd0, addr_ok}, 1);
        cyc_at(); chk("t2 wstrb sb", {28'd0, wstrb}, 4'b1000);
        chk("t2 awsize", {29'd0, awsize}, 0);
        chk("t2 wdata", wdata_axi, 32'hAB00_0000);
        cyc_at();
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
        chk("t2 data_ok@2", {31'd0, data_ok}, 1);
`else
        chk("t2 no data_ok@2", {31'd0, data_ok}, 0);
        cyc_at(); chk("t2 data_ok@3", {31'd0, data_ok}, 1);
`endif
        wait_idle();
        push(1, 2'd1, 32'h2000_0002, 32'h1234_0000);
        cyc_at(); cyc_at(); chk("t2 wstrb sh", {28'd0, wstrb}, 4'b1100);
        wait_idle();

        // Skewed AW/W handshakes.
        p_aw = 0;
        push(1, 2'd2, 32'h3000_0008, 32'h0000_0055);
        cyc_at();
        cyc_at(); chk("t3 wvalid@1", {31'd0, wvalid}, 1);
        p_w = 0;
        cyc_at(); chk("t3 wvalid low@2", {31'd0, wvalid}, 0);
        chk("t3 awvalid@2", {31'd0, awvalid}, 1);
        cyc_at(); chk("t3 awvalid@3", {31'd0, awvalid}, 1);
        p_aw = 100;
        cyc_at(); chk("t3 awvalid@4", {31'd0, awvalid}, 1);
        chk("t3 awaddr held", awaddr, 32'h3000_0008);
        cyc_at(); chk("t3 bready@5", {31'd0, bready}, 1);
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
        chk("t3 data_ok@5", {31'd0, data_ok}, 1);
`else
        chk("t3 no early data_ok", {31'd0, data_ok}, 0);
        cyc_at(); chk("t3 data_ok@6", {31'd0, data_ok}, 1);
`endif
        all_ready();
        wait_idle();

        // Back-to-back reads with req held, AR stalled.
        p_ar = 0;
        push(0, 2'd2, 32'h4000_0010, 0);
        push(0, 2'd1, 32'h4000_0022, 0);
        cyc_at(); chk("t4 addr_ok@0", {31'd0, addr_ok}, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc_at();
            chk("t4 arvalid stall", {31'd0, arvalid}, 1);
            chk("t4 araddr stable", araddr, 32'h4000_0010);
        end
        p_ar = 100;
        cyc_at(); chk("t4 arvalid@6", {31'd0, arvalid}, 1);
        cyc_at(); chk("t4 rready@7", {31'd0, rready}, 1);
        cyc_at(); chk("t4 data_ok@8", {31'd0, data_ok}, 1);
        chk("t4 no addr_ok@8", {31'd0, addr_ok}, 0);
        cyc_at(); chk("t4 second addr_ok@9", {31'd0, addr_ok}, 1);
        wait_idle();

        // Async reset in R state.
        p_r = 0;
        push(0, 2'd2, 32'h5000_0000, 0);
        cyc_at(); cyc_at(); cyc_at();
        chk("t5 in R", {31'd0, rready}, 1);
        @(posedge clk); #3 rst = 0;
        #1;
        chk("t5 rready low", {31'd0, rready}, 0);
        chk("t5 arvalid low", {31'd0, arvalid}, 0);
        chk("t5 data_ok low", {31'd0, data_ok}, 0);
        p_r = 100;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        wait_idle();
        fix_rd = 1; fix_val = 32'h600D_F00D;
        push(0, 2'd2, 32'h5000_0004, 0);
        cyc_at(); cyc_at(); cyc_at(); cyc_at();
        chk("t5 post data_ok@3", {31'd0, data_ok}, 1);
        chk("t5 post rdata", rdata, 32'h600D_F00D);
        fix_rd = 0;
        wait_idle();

        // Write with delayed B and a second request waiting.
        p_b = 0;
        push(1, 2'd2, 32'h6000_0000, 32'hCAFE_0001);
        push(1, 2'd2, 32'h6000_0004, 32'hCAFE_0002);
        cyc_at(); chk("t6 addr_ok@0", {31'd0, addr_ok}, 1);
        cyc_at();
        cyc_at();
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
        chk("t6 data_ok@2", {31'd0, data_ok}, 1);
`else
        chk("t6 no data_ok@2", {31'd0, data_ok}, 0);
`endif
        for (int i = 3; i <= 7; i++) begin
            cyc_at();
            chk("t6 addr_ok held off", {31'd0, addr_ok}, 0);
            chk("t6 data_ok quiet", {31'd0, data_ok}, 0);
        end
        p_b = 100;
        cyc_at(); chk("t6 bready@8", {31'd0, bready}, 1);
`ifdef SRAM_BRIDGE_WR_FAST_OK_EN
        cyc_at(); chk("t6 next addr_ok@9", {31'd0, addr_ok}, 1);
`else
        cyc_at(); chk("t6 data_ok@9", {31'd0, data_ok}, 1);
        cyc_at(); chk("t6 next addr_ok@10", {31'd0, addr_ok}, 1);
`endif
        wait_idle();

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 300; n++) begin
            p_ar = 30 + int'($urandom_range(70));
            p_r  = 30 + int'($urandom_range(70));
            p_aw = 30 + int'($urandom_range(70));
            p_w  = 30 + int'($urandom_range(70));
            p_b  = 30 + int'($urandom_range(70));
            push(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, $urandom);
            if ($urandom_range(3) == 0) wait_idle();
            else repeat (int'($urandom_range(6))) @(posedge clk);
        end
        all_ready();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
